// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order FIFO of fetch predictions, resolved at execute to drive
// predictor updates, redirects and flushes of wrong-path entries on a mispredict.
module branch_resolve_queue #(
  parameter int QUEUE_DEPTH     = 8,
  parameter int INSTR_SIZE_BYTE = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [INSTR_SIZE_BYTE*8-1:0] in_fetch_pc,
  input  logic                         in_fetch_nop,
  input  logic                         in_pred_taken,
  input  logic [INSTR_SIZE_BYTE*8-1:0] in_pred_offset,
  output logic                         out_fetch_stall,
  input  logic                         in_exe_valid,
  input  logic                         in_exe_is_branch,
  input  logic                         in_exe_taken,
  input  logic [INSTR_SIZE_BYTE*8-1:0] in_exe_offset,
  output logic [INSTR_SIZE_BYTE*8-1:0] out_exe_pc,
  output logic                         out_exe_nop,
  output logic                         out_exe_branch_taken,
  output logic [INSTR_SIZE_BYTE*8-1:0] out_exe_branch_offset,
  output logic                         out_redirect,
  output logic [INSTR_SIZE_BYTE*8-1:0] out_redirect_pc,
  output logic [15:0]                  out_branch_count,
  output logic [15:0]                  out_mispredict_count,
  output logic                         out_error
);
  localparam int W  = INSTR_SIZE_BYTE * 8;
  localparam int AW = $clog2(QUEUE_DEPTH);
  logic [W-1:0] pc_mem [QUEUE_DEPTH];
  logic [W-1:0] off_mem [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] taken_mem;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic full, pop, push, mis, br_pop, err_now;
  logic [W-1:0] head_pc, head_off, redirect_pc;
  logic head_taken;
  always_comb begin
    full        = count == (AW+1)'(QUEUE_DEPTH);
    pop         = in_exe_valid && count != '0;
    head_pc     = pc_mem[rd_ptr];
    head_off    = off_mem[rd_ptr];
    head_taken  = taken_mem[rd_ptr];
    br_pop      = pop && in_exe_is_branch;
    mis         = br_pop && (head_taken != in_exe_taken || (in_exe_taken && head_off != in_exe_offset));
    // a pop frees a slot for a same-cycle push only when it does not flush the queue
    push        = !in_fetch_nop && !mis && (!full || pop);
    err_now     = (in_exe_valid && count == '0) || (!in_fetch_nop && full && !(pop && !mis));
    redirect_pc = in_exe_taken ? head_pc + in_exe_offset : head_pc + W'(INSTR_SIZE_BYTE);
  end
  assign out_fetch_stall = full;
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= in_fetch_pc;
      off_mem[wr_ptr]   <= in_pred_offset;
      taken_mem[wr_ptr] <= in_pred_taken;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr                <= '0;
      wr_ptr                <= '0;
      count                 <= '0;
      out_exe_pc            <= '0;
      out_exe_nop           <= 1'b1;
      out_exe_branch_taken  <= 1'b0;
      out_exe_branch_offset <= '0;
      out_redirect          <= 1'b0;
      out_redirect_pc       <= '0;
      out_branch_count      <= '0;
      out_mispredict_count  <= '0;
      out_error             <= 1'b0;
    end else begin
      rd_ptr      <= mis ? '0 : rd_ptr + AW'(pop);
      wr_ptr      <= mis ? '0 : wr_ptr + AW'(push);
      count       <= mis ? '0 : count + (AW+1)'(push) - (AW+1)'(pop);
      out_exe_nop <= !br_pop;
      out_redirect <= mis;
      out_error   <= out_error || err_now;
      if (br_pop) begin
        out_exe_pc            <= head_pc;
        out_exe_branch_taken  <= in_exe_taken;
        out_exe_branch_offset <= in_exe_offset;
        out_branch_count      <= out_branch_count + 16'(out_branch_count != 16'hFFFF);
      end
      if (mis) begin
        out_redirect_pc      <= redirect_pc;
        out_mispredict_count <= out_mispredict_count + 16'(out_mispredict_count != 16'hFFFF);
      end
    end
  end
endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb_branch_resolve_queue: directed scenarios plus random traffic against a queue-based model.
module tb_branch_resolve_queue;
  localparam int D = 8;
  logic clk = 0, rst_n = 0;
  logic [31:0] in_fetch_pc = 0, in_pred_offset = 0, in_exe_offset = 0;
  logic in_fetch_nop = 1, in_pred_taken = 0, in_exe_valid = 0, in_exe_is_branch = 0, in_exe_taken = 0;
  logic out_fetch_stall, out_exe_nop, out_exe_branch_taken, out_redirect, out_error;
  logic [31:0] out_exe_pc, out_exe_branch_offset, out_redirect_pc;
  logic [15:0] out_branch_count, out_mispredict_count;
  int n_cmp = 0, n_bad = 0;
  typedef struct packed {logic [31:0] pc; logic t; logic [31:0] off;} ent_t;
  ent_t q[$];
  logic m_nop = 1, m_tk = 0, m_red = 0, m_err = 0;
  logic [31:0] m_pc = 0, m_off = 0, m_rpc = 0;
  logic [15:0] m_bc = 0, m_mc = 0;

  branch_resolve_queue dut (
    .clk(clk), .rst_n(rst_n), .in_fetch_pc(in_fetch_pc), .in_fetch_nop(in_fetch_nop),
    .in_pred_taken(in_pred_taken), .in_pred_offset(in_pred_offset), .out_fetch_stall(out_fetch_stall),
    .in_exe_valid(in_exe_valid), .in_exe_is_branch(in_exe_is_branch), .in_exe_taken(in_exe_taken),
    .in_exe_offset(in_exe_offset), .out_exe_pc(out_exe_pc), .out_exe_nop(out_exe_nop),
    .out_exe_branch_taken(out_exe_branch_taken), .out_exe_branch_offset(out_exe_branch_offset),
    .out_redirect(out_redirect), .out_redirect_pc(out_redirect_pc), .out_branch_count(out_branch_count),
    .out_mispredict_count(out_mispredict_count), .out_error(out_error));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_nop = 1; m_tk = 0; m_red = 0; m_err = 0; m_pc = 0; m_off = 0; m_rpc = 0; m_bc = 0; m_mc = 0;
  endtask

  task automatic check_reset_state();
    chk("rst_nop", out_exe_nop, 1);
    chk("rst_redirect", out_redirect, 0);
    chk("rst_rpc", out_redirect_pc, 0);
    chk("rst_bc", out_branch_count, 0);
    chk("rst_mc", out_mispredict_count, 0);
    chk("rst_err", out_error, 0);
    chk("rst_stall", out_fetch_stall, 0);
    chk("rst_pc", out_exe_pc, 0);
  endtask

  task automatic do_reset();
    in_fetch_nop = 1; in_exe_valid = 0;
    @(negedge clk);
    rst_n = 0;
    #1;
    model_clear();
    check_reset_state();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic step(input logic fnop, input logic [31:0] fpc, input logic pt, input logic [31:0] poff,
                      input logic v, input logic br, input logic tk, input logic [31:0] off);
    int n;
    logic pop, mis;
    ent_t e;
    in_fetch_nop = fnop; in_fetch_pc = fpc; in_pred_taken = pt; in_pred_offset = poff;
    in_exe_valid = v; in_exe_is_branch = br; in_exe_taken = tk; in_exe_offset = off;
    n = q.size();
    pop = v && n > 0;
    mis = 0;
    e = '0;
    if (v && n == 0) m_err = 1;
    if (pop) begin
      e = q.pop_front();
      if (br) begin
        mis = (e.t != tk) || (tk && e.off != off);
        m_pc = e.pc; m_tk = tk; m_off = off;
        if (m_bc != 16'hFFFF) m_bc++;
      end
    end
    m_nop = !(pop && br);
    if (!fnop) begin
      if (n < D || (pop && !mis)) begin
        if (!mis) q.push_back('{fpc, pt, poff});
      end else m_err = 1;
    end
    if (mis) begin
      q.delete();
      m_rpc = tk ? e.pc + off : e.pc + 32'd4;
      if (m_mc != 16'hFFFF) m_mc++;
    end
    m_red = mis;
    @(posedge clk);
    #1;
    chk("exe_nop", out_exe_nop, m_nop);
    chk("redirect", out_redirect, m_red);
    chk("error", out_error, m_err);
    chk("branch_count", out_branch_count, m_bc);
    chk("mispredict_count", out_mispredict_count, m_mc);
    chk("stall", out_fetch_stall, q.size() == D);
    if (!m_nop) begin
      chk("exe_pc", out_exe_pc, m_pc);
      chk("exe_taken", out_exe_branch_taken, m_tk);
      chk("exe_offset", out_exe_branch_offset, m_off);
    end
    if (m_red) chk("redirect_pc", out_redirect_pc, m_rpc);
  endtask

  task automatic push(input logic [31:0] pc, input logic pt, input logic [31:0] poff);
    step(0, pc, pt, poff, 0, 0, 0, 0);
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #12;
    check_reset_state();
    @(negedge clk);
    rst_n = 1;
    // correct prediction
    push(32'h100, 1, 32'h40);
    step(1, 0, 0, 0, 1, 1, 1, 32'h40);
    chk("tp1_pc", out_exe_pc, 32'h100);
    chk("tp1_bc", out_branch_count, 1);
    // taken mispredict flushes younger entries
    do_reset();
    push(32'h200, 0, 0);
    push(32'h204, 0, 0);
    push(32'h208, 0, 0);
    step(1, 0, 0, 0, 1, 1, 1, 32'h20);
    chk("tp2_rpc", out_redirect_pc, 32'h220);
    idle();
    step(1, 0, 0, 0, 1, 1, 0, 0);
    chk("tp2_underflow", out_error, 1);
    // not-taken mispredict
    do_reset();
    push(32'h300, 1, 32'h10);
    step(1, 0, 0, 0, 1, 1, 0, 0);
    chk("tp3_rpc", out_redirect_pc, 32'h304);
    // full boundary, then push+pop while full, then drain in FIFO order
    do_reset();
    for (int i = 0; i < D; i++) push(32'h1000 + 4 * i, 0, 0);
    chk("tp4_stall", out_fetch_stall, 1);
    push(32'h2000, 0, 0);
    chk("tp4_overflow", out_error, 1);
    step(0, 32'h3000, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < D; i++) step(1, 0, 0, 0, 1, 1, 0, 0);
    // non-branch traffic wrapping the pointers
    do_reset();
    push(32'h4000, 0, 0);
    for (int i = 1; i <= 20; i++) step(0, 32'h4000 + 4 * i, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 1, 1, 0, 0);
    chk("tp5_wrap_pc", out_exe_pc, 32'h4050);
    // asynchronous reset with a mispredicting pop pending
    do_reset();
    for (int i = 0; i < 5; i++) push(32'h5000 + 4 * i, 1, 32'h8);
    step(0, 32'h5014, 1, 32'h8, 1, 1, 1, 32'h8);
    in_fetch_nop = 1; in_exe_valid = 1; in_exe_is_branch = 1; in_exe_taken = 0;
    #3;
    rst_n = 0;
    #1;
    model_clear();
    check_reset_state();
    in_exe_valid = 0;
    @(negedge clk);
    rst_n = 1;
    step(1, 0, 0, 0, 1, 1, 0, 0);
    chk("tp6_empty_after_reset", out_error, 1);
    // random traffic
    for (int blk = 0; blk < 8; blk++) begin
      do_reset();
      for (int c = 0; c < 250; c++) begin
        logic [31:0] offs [4];
        logic fnop, pt, v, br, tk;
        logic [31:0] poff, off;
        offs = '{32'h10, 32'h20, 32'h40, $urandom};
        fnop = $urandom_range(0, 9) < 3;
        pt = $urandom_range(0, 1);
        poff = offs[$urandom_range(0, 3)];
        v = $urandom_range(0, 9) < 4;
        br = $urandom_range(0, 9) < 6;
        tk = $urandom_range(0, 1);
        off = offs[$urandom_range(0, 3)];
        if (q.size() > 0 && $urandom_range(0, 3) != 0) begin
          tk = q[0].t;
          off = q[0].off;
        end
        step(fnop, $urandom & 32'hFFFF_FFFC, pt, poff, v, br, tk, off);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
